// File: rtl/sp_transformation.sv
`default_nettype none
// ============================================================================
//  Module   : sp_transformation
//  Brief    : Streebog S (pi substitution) and P (8x8 byte transpose) steps
//  Revision : 1.0 - initial release
// ============================================================================

module sp_transformation #(
  parameter int DATA_WIDTH     = 512,
  parameter int SBOX_PER_CYCLE = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] sp_data_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] sp_data_o,
  output logic                  sp_valid_out_o
);

  localparam int STEPS = 64 / SBOX_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEPS - 1);

  localparam logic [7:0] PI [256] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   work_q, work_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic [5:0]              byte_idx;

  // Output byte (8r+c) takes substituted byte (8c+r)
  function automatic logic [DATA_WIDTH-1:0] transpose(input logic [DATA_WIDTH-1:0] blk);
    transpose = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        transpose[(8*r+c)*8 +: 8] = blk[(8*c+r)*8 +: 8];
      end
    end
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    byte_idx = '0;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          work_d  = sp_data_i;
          cnt_d   = '0;
          state_d = SUB;
        end
      end
      SUB: begin
        for (int j = 0; j < SBOX_PER_CYCLE; j++) begin
          byte_idx = 6'(int'(cnt_q) * SBOX_PER_CYCLE + j);
          work_d[{byte_idx, 3'b000} +: 8] = PI[work_q[{byte_idx, 3'b000} +: 8]];
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        data_d  = transpose(work_q);
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready_o        = (state_q == IDLE);
  assign sp_data_o      = data_q;
  assign sp_valid_out_o = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_sp_transformation.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sp_transformation
//  Brief    : Self-checking bench for sp_transformation (S+P of Streebog)
//  Revision : 1.0 - initial release
// ============================================================================

module tb_sp_transformation;

  logic         clk;
  logic         rst;
  logic         v8;
  logic         v_s;
  logic [511:0] din;

  logic         rdy8, rdy1, rdy64;
  logic [511:0] dout8, dout1, dout64;
  logic         pv8, pv1, pv64;

  int total = 0;
  int bad   = 0;

  sp_transformation #(.DATA_WIDTH(512), .SBOX_PER_CYCLE(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .valid_in(v8), .sp_data_i(din),
    .ready_o(rdy8), .sp_data_o(dout8), .sp_valid_out_o(pv8)
  );

  sp_transformation #(.DATA_WIDTH(512), .SBOX_PER_CYCLE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_in(v_s), .sp_data_i(din),
    .ready_o(rdy1), .sp_data_o(dout1), .sp_valid_out_o(pv1)
  );

  sp_transformation #(.DATA_WIDTH(512), .SBOX_PER_CYCLE(64)) dut64 (
    .clk_i(clk), .rst_i(rst), .valid_in(v_s), .sp_data_i(din),
    .ready_o(rdy64), .sp_data_o(dout64), .sp_valid_out_o(pv64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference pi table of GOST R 34.11-2012
  logic [7:0] pi_ref [256] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  function automatic logic [511:0] ref_sp(input logic [511:0] blk);
    logic [7:0] s [64];
    logic [511:0] o;
    for (int k = 0; k < 64; k++) s[k] = pi_ref[blk[k*8 +: 8]];
    o = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        o[(8*r+c)*8 +: 8] = s[8*c+r];
    return o;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int w = 0; w < 16; w++) b[w*32 +: 32] = $urandom();
    return b;
  endfunction

  task automatic check_vec(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts and ends at a falling edge; DUT with 8 bytes/cycle must be idle
  task automatic run_block8(input string tag, input logic [511:0] blk, input logic [511:0] exp);
    int lat;
    logic [511:0] got;
    lat = 0;
    got = '0;
    check_int({tag, "_ready"}, int'(rdy8), 1);
    din = blk;
    v8  = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      v8 = 1'b0;
      if (pv8) begin
        lat = i;
        got = dout8;
        break;
      end
    end
    check_int({tag, "_latency"}, lat - 1, 9);
    check_vec({tag, "_data"}, got, exp);
    @(negedge clk);
    check_int({tag, "_pulse_width"}, int'(pv8), 0);
    check_vec({tag, "_hold"}, dout8, got);
  endtask

  initial begin
    logic [511:0] blk;
    logic [511:0] exp;
    logic [511:0] bb [41];
    int n8, n1, n64, l8, l1, l64;
    logic [511:0] d8, d1, d64;

    rst = 1'b1;
    v8  = 1'b0;
    v_s = 1'b0;
    din = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_int("rst_ready8", int'(rdy8), 1);
    check_int("rst_valid8", int'(pv8), 0);
    check_vec("rst_data8", dout8, '0);
    check_int("rst_ready_sweep", int'({rdy1, rdy64}), 3);
    check_int("rst_valid_sweep", int'({pv1, pv64}), 0);
    check_vec("rst_data_sweep", dout1 | dout64, '0);

    // Directed patterns with hand-written expected values
    run_block8("zero", '0, {64{8'hFC}});
    blk = '0; blk[15:8] = 8'h02;
    exp = {64{8'hFC}}; exp[8*8 +: 8] = 8'hDD;
    run_block8("transpose", blk, exp);
    blk = '0; blk[7:0] = 8'h01; blk[511:504] = 8'hFF;
    exp = {64{8'hFC}}; exp[7:0] = 8'hEE; exp[511:504] = 8'hB6;
    run_block8("corners", blk, exp);

    for (int t = 0; t < 3; t++) begin
      blk = rand_block();
      run_block8($sformatf("rand%0d", t), blk, ref_sp(blk));
    end

    // valid held high with fresh data each cycle: accept every 10th cycle
    for (int j = 0; j <= 40; j++) begin
      check_int($sformatf("b2b_ready_%0d", j), int'(rdy8), (j % 10 == 0) ? 1 : 0);
      check_int($sformatf("b2b_pulse_%0d", j), int'(pv8), (j >= 10 && j % 10 == 0) ? 1 : 0);
      if (j >= 10 && j % 10 == 0)
        check_vec($sformatf("b2b_data_%0d", j), dout8, ref_sp(bb[j-10]));
      bb[j] = rand_block();
      din   = bb[j];
      v8    = (j <= 30);
      @(negedge clk);
    end

    // Reset during the 4th SUB edge aborts the block
    din = rand_block();
    v8  = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_int("abort_ready", int'(rdy8), 1);
    check_int("abort_valid", int'(pv8), 0);
    check_vec("abort_data", dout8, '0);
    n8 = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (pv8) n8++;
    end
    check_int("abort_no_pulse", n8, 0);
    blk = rand_block();
    run_block8("after_abort", blk, ref_sp(blk));

    // Every byte value once across 4 blocks, on all three throughput settings
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 64; k++) blk[k*8 +: 8] = 8'(b * 64 + k);
      check_int($sformatf("sweep%0d_ready", b), int'({rdy8, rdy1, rdy64}), 7);
      din = blk;
      v8  = 1'b1;
      v_s = 1'b1;
      n8 = 0; n1 = 0; n64 = 0; l8 = 0; l1 = 0; l64 = 0;
      d8 = '0; d1 = '0; d64 = '0;
      for (int i = 1; i <= 70; i++) begin
        @(negedge clk);
        v8  = 1'b0;
        v_s = 1'b0;
        if (pv8)  begin n8++;  l8  = i; d8  = dout8;  end
        if (pv1)  begin n1++;  l1  = i; d1  = dout1;  end
        if (pv64) begin n64++; l64 = i; d64 = dout64; end
      end
      check_int($sformatf("sweep%0d_pulses8", b), n8, 1);
      check_int($sformatf("sweep%0d_pulses1", b), n1, 1);
      check_int($sformatf("sweep%0d_pulses64", b), n64, 1);
      check_int($sformatf("sweep%0d_lat8", b), l8 - 1, 64 / 8 + 1);
      check_int($sformatf("sweep%0d_lat1", b), l1 - 1, 64 / 1 + 1);
      check_int($sformatf("sweep%0d_lat64", b), l64 - 1, 64 / 64 + 1);
      check_vec($sformatf("sweep%0d_data8", b), d8, ref_sp(blk));
      check_vec($sformatf("sweep%0d_data1", b), d1, ref_sp(blk));
      check_vec($sformatf("sweep%0d_data64", b), d64, ref_sp(blk));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sp_transformation.md
SP_TRANSFORMATION -- requirements
Module: sp_transformation

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, block width in bits; only 512 is legal.
REQ-002 SHALL have parameter SBOX_PER_CYCLE, default 8, bytes substituted per clock; legal values are 1, 2, 4, 8, 16, 32 and 64.
REQ-003 SHALL have port clk_i  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port valid_in  input  1  input block valid.
REQ-006 SHALL have port sp_data_i  input  DATA_WIDTH  input block; byte k = bits [8k+7:8k].
REQ-007 SHALL have port ready_o  output  1  block can accept a new input this cycle.
REQ-008 SHALL have port sp_data_o  output  DATA_WIDTH  P(S(input)); feeds l_transformation l_data_i.
REQ-009 SHALL have port sp_valid_out_o  output  1  one-cycle pulse marking new sp_data_o; feeds l_transformation valid_in.

Function
REQ-010 SHALL implement the Streebog (GOST R 34.11-2012) S and P steps that precede L in the LPS round.
REQ-011 SHALL apply the standard 256-entry pi S-box to every byte; pi[0x00]=0xFC, pi[0x01]=0xEE, pi[0x02]=0xDD, pi[0xFF]=0xB6.
REQ-012 SHALL apply P as an 8x8 byte transpose: output byte (8r+c) = substituted byte (8c+r), for r,c in 0..7.
REQ-013 SHALL use an FSM with states IDLE, SUB and DONE; ready_o SHALL be 1 exactly when state is IDLE, decoded combinationally from state.
REQ-014 In IDLE, if valid_in=1 at a rising edge: capture sp_data_i into the work register, clear the byte counter, and go to SUB.
REQ-015 In IDLE, if valid_in=0: remain in IDLE.
REQ-016 In SUB, each edge SHALL replace work bytes cnt*SBOX_PER_CYCLE .. cnt*SBOX_PER_CYCLE+SBOX_PER_CYCLE-1 with their pi values and increment cnt.
REQ-017 The counter SHALL be ceil(log2(64/SBOX_PER_CYCLE)) bits wide, minimum 1.
REQ-018 In SUB, when cnt = 64/SBOX_PER_CYCLE-1, the FSM SHALL go to DONE.
REQ-019 In DONE, at the edge: load sp_data_o with P(work), set sp_valid_out_o to 1, and go to IDLE.
REQ-020 Latency: for an input accepted at edge N, sp_data_o and sp_valid_out_o SHALL update at edge N+64/SBOX_PER_CYCLE+1 (edge N+9 for the default).
REQ-021 sp_valid_out_o SHALL be high for exactly one cycle per accepted block and 0 at every other time.
REQ-022 sp_data_o SHALL hold its value until the next DONE edge.
REQ-023 valid_in and sp_data_i SHALL be ignored while ready_o=0: no capture, no queueing, no error flag; the upstream holds the data.
REQ-024 A block may be accepted in the same cycle that sp_valid_out_o is high (back-to-back operation); throughput is one block per 64/SBOX_PER_CYCLE+2 cycles.
REQ-025 No backpressure from downstream: sp_valid_out_o SHALL be issued unconditionally.

Reset
REQ-026 At any edge with rst_i=1: state becomes IDLE, cnt=0, work=0, sp_data_o=0, sp_valid_out_o=0; valid_in is ignored.
REQ-027 ready_o SHALL read 1 in the cycle after a reset edge.
REQ-028 Reset asserted during SUB or DONE SHALL abort the block; no sp_valid_out_o pulse SHALL appear for it.

Verification
REQ-029 Scenario: sp_data_i all zero accepted -> exactly one sp_valid_out_o pulse 9 edges later, with sp_data_o = 64 bytes of 0xFC.
REQ-030 Scenario: byte1=0x02, all other bytes 0x00 -> sp_data_o byte8=0xDD, all other bytes 0xFC (checks the transpose).
REQ-031 Scenario: byte0=0x01 and byte63=0xFF, all other bytes 0x00 -> sp_data_o byte0=0xEE, byte63=0xB6, all other bytes 0xFC.
REQ-032 Scenario: valid_in held at 1 with new data every cycle -> ready_o low for 9 cycles out of every 10; only the data present in ready cycles is processed; one pulse every 10 cycles.
REQ-033 Scenario: rst_i pulsed at the 4th SUB cycle -> no pulse; sp_data_o=0; ready_o=1 in the next cycle; the next block completes with normal latency.
REQ-034 Scenario: exhaustive pi check via a reference model over 256 inputs, and a sweep of SBOX_PER_CYCLE over 1, 8 and 64 -> latency equals 64/SBOX_PER_CYCLE+1 edges and data is identical across all settings.
